// File: rtl/coremem_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : coremem_mp_if
// Brief    : Per-port memory-bus bundle between processor ports and core memory.
// Revision : 1.0
// ============================================================================
interface coremem_mp_if #(
   parameter int NPORTS = 4
);
   logic [NPORTS-1:0]    memsel;
   logic [NPORTS-1:0]    mc_rq_cyc;
   logic [NPORTS-1:0]    mc_rd_rq;
   logic [NPORTS-1:0]    mc_wr_rq;
   logic [NPORTS-1:0]    mc_wr_rs;
   logic [NPORTS-1:0]    fmc_select;
   logic [NPORTS*14-1:0] ma;
   logic [NPORTS*4-1:0]  sel;
   logic [NPORTS*36-1:0] mb_in;
   logic [NPORTS-1:0]    cmc_addr_ack;
   logic [NPORTS-1:0]    cmc_rd_rs;
   logic [NPORTS*36-1:0] mb_out;

   modport master (
      output memsel, mc_rq_cyc, mc_rd_rq, mc_wr_rq, mc_wr_rs, fmc_select, ma, sel, mb_in,
      input  cmc_addr_ack, cmc_rd_rs, mb_out
   );

   modport slave (
      input  memsel, mc_rq_cyc, mc_rd_rq, mc_wr_rq, mc_wr_rs, fmc_select, ma, sel, mb_in,
      output cmc_addr_ack, cmc_rd_rs, mb_out
   );
endinterface
`default_nettype wire

// File: rtl/coremem_mp.sv
`default_nettype none
// ============================================================================
// Module   : coremem_mp
// Brief    : Parametrised multi-port core memory with fixed-priority arbitration
//            and read-restore / clear-write / read-modify-write cycles.
// Revision : 1.0
// ============================================================================
module coremem_mp #(
   parameter int ADDR_BITS = 14,
   parameter int BASE      = 0,
   parameter int NPORTS    = 4,
   parameter int ACK_DLY   = 2,
   parameter int RD_DLY    = 4,
   parameter int WR_DLY    = 4
) (
   input  logic        clk,
   input  logic        reset,
   coremem_mp_if.slave bus
);
   localparam int c_pw    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int c_hi    = 18 - ADDR_BITS;
   localparam int c_cw    = 16;
   localparam int c_words = 2 ** ADDR_BITS;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACK   = 3'd1,
      S_RD    = 3'd2,
      S_WWAIT = 3'd3,
      S_WRITE = 3'd4,
      S_REL   = 3'd5
   } state_t;

   logic [35:0] core [c_words];

   state_t               r_state, w_state_nx;
   logic [c_cw-1:0]      r_cnt, w_cnt_nx;
   logic [c_pw-1:0]      r_port, w_port;
   logic [ADDR_BITS-1:0] r_word;
   logic                 r_rd, r_wr;
   logic [35:0]          r_sense, r_data;
   logic [NPORTS-1:0]    r_ack, r_rd_rs, r_wr_rs_q;
   logic [NPORTS*36-1:0] r_mb_out;

   logic [NPORTS-1:0]    w_elig;
   logic [ADDR_BITS-1:0] w_word [NPORTS];
   logic                 w_hit, w_latch, w_ack, w_rd_rs, w_core_rd, w_core_wr;
   logic                 w_wr_latch, w_rel_exit, w_cyc, w_wr_rise;

   generate
      for (genvar p = 0; p < NPORTS; p++) begin : g_port
         logic [17:0] w_addr;
         assign w_addr    = {bus.sel[p*4 +: 4], bus.ma[p*14 +: 14]};
         assign w_word[p] = w_addr[ADDR_BITS-1:0];
         assign w_elig[p] = bus.mc_rq_cyc[p] & (bus.mc_rd_rq[p] | bus.mc_wr_rq[p]) &
                            bus.memsel[p] & ~bus.fmc_select[p] &
                            (w_addr[17:ADDR_BITS] == c_hi'(BASE));
      end
   endgenerate

   // Lowest-numbered eligible port wins.
   always_comb begin
      w_hit  = 1'b0;
      w_port = '0;
      for (int p = NPORTS - 1; p >= 0; p--) begin
         if (w_elig[p]) begin
            w_hit  = 1'b1;
            w_port = c_pw'(p);
         end
      end
   end

   assign w_cyc     = bus.mc_rq_cyc[r_port];
   assign w_wr_rise = bus.mc_wr_rs[r_port] & ~r_wr_rs_q[r_port];

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + 1'b1;
      w_latch    = 1'b0;
      w_ack      = 1'b0;
      w_rd_rs    = 1'b0;
      w_core_rd  = 1'b0;
      w_core_wr  = 1'b0;
      w_wr_latch = 1'b0;
      w_rel_exit = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nx = '0;
            if (w_hit) begin
               w_latch    = 1'b1;
               w_state_nx = S_ACK;
            end
         end
         S_ACK: begin
            if (r_cnt == c_cw'(ACK_DLY - 1)) begin
               w_ack      = 1'b1;
               w_core_rd  = 1'b1;
               w_cnt_nx   = '0;
               w_state_nx = r_rd ? S_RD : S_WWAIT;
            end
         end
         S_RD: begin
            if (r_cnt == c_cw'(RD_DLY - 1)) begin
               w_rd_rs    = 1'b1;
               w_cnt_nx   = '0;
               w_state_nx = r_wr ? S_WWAIT : S_WRITE;
            end
         end
         S_WWAIT: begin
            w_cnt_nx = '0;
            if (w_wr_rise) begin
               w_wr_latch = 1'b1;
               w_state_nx = S_WRITE;
            end else if (!w_cyc) begin
               w_state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            if (r_cnt == c_cw'(WR_DLY - 1)) begin
               w_core_wr  = 1'b1;
               w_cnt_nx   = '0;
               w_state_nx = S_REL;
            end
         end
         S_REL: begin
            w_cnt_nx = '0;
            if (!w_cyc) begin
               w_rel_exit = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // r_data holds the fallback write-back value (sense or original word) until mb_in replaces it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_port    <= '0;
         r_word    <= '0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_sense   <= '0;
         r_data    <= '0;
         r_ack     <= '0;
         r_rd_rs   <= '0;
         r_wr_rs_q <= '0;
         r_mb_out  <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_wr_rs_q <= bus.mc_wr_rs;
         r_ack     <= '0;
         r_rd_rs   <= '0;
         if (w_latch) begin
            r_port <= w_port;
            r_word <= w_word[w_port];
            r_rd   <= bus.mc_rd_rq[w_port];
            r_wr   <= bus.mc_wr_rq[w_port];
         end
         if (w_ack) begin
            r_ack[r_port] <= 1'b1;
         end
         if (w_core_rd) begin
            r_data <= core[r_word];
            if (r_rd) begin
               r_sense <= core[r_word];
            end
         end
         if (w_rd_rs) begin
            r_rd_rs[r_port]            <= 1'b1;
            r_mb_out                   <= '0;
            r_mb_out[r_port*36 +: 36] <= r_sense;
         end
         if (w_wr_latch) begin
            r_data <= bus.mb_in[r_port*36 +: 36];
         end
         if (w_rel_exit) begin
            r_mb_out <= '0;
         end
      end
   end

   // Core array keeps its contents across reset, like real core.
   always_ff @(posedge clk) begin
      if (w_core_rd) begin
         core[r_word] <= '0;
      end else if (w_core_wr) begin
         core[r_word] <= r_data;
      end
   end

   assign bus.cmc_addr_ack = r_ack;
   assign bus.cmc_rd_rs    = r_rd_rs;
   assign bus.mb_out       = r_mb_out;
endmodule
`default_nettype wire

// File: tb/tb_coremem_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_coremem_mp
// Brief    : Scoreboard bench for coremem_mp: read, write, RMW, priority, misses, reset.
// Revision : 1.0
// ============================================================================
module tb_coremem_mp;
   localparam int NP      = 4;
   localparam int ACK_DLY = 2;
   localparam int RD_DLY  = 4;
   localparam int WR_DLY  = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   coremem_mp_if #(.NPORTS(NP)) bus ();

   coremem_mp #(
      .ADDR_BITS(14), .BASE(0), .NPORTS(NP),
      .ACK_DLY(ACK_DLY), .RD_DLY(RD_DLY), .WR_DLY(WR_DLY)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int          port;
      logic [35:0] data;
   } rd_exp_t;

   int      exp_ack_q[$];
   rd_exp_t exp_rd_q[$];
   int      n_checks = 0;
   int      n_pass   = 0;
   int      n_ack[NP] = '{default: 0};
   int      n_rd[NP]  = '{default: 0};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // Scoreboard: every ack / rd_rs pulse must match the head of its queue.
   always @(negedge clk) begin
      rd_exp_t e;
      if (reset === 1'b0) begin
         for (int p = 0; p < NP; p++) begin
            if (bus.cmc_addr_ack[p] === 1'b1) begin
               n_ack[p]++;
               if (exp_ack_q.size() == 0) check("ack_unexpected", p, 99);
               else check("ack_port", p, exp_ack_q.pop_front());
            end
            if (bus.cmc_rd_rs[p] === 1'b1) begin
               n_rd[p]++;
               if (exp_rd_q.size() == 0) check("rd_unexpected", p, 99);
               else begin
                  e = exp_rd_q.pop_front();
                  check("rd_port", p, e.port);
                  for (int q = 0; q < NP; q++)
                     check("mb_out", bus.mb_out[q*36 +: 36], (q == e.port) ? e.data : 36'd0);
               end
            end
         end
      end
   end

   task automatic drive_req(input int p, input logic [17:0] addr, input bit rd, input bit wr);
      bus.sel[p*4 +: 4]   = addr[17:14];
      bus.ma[p*14 +: 14]  = addr[13:0];
      bus.mc_rd_rq[p]     = rd;
      bus.mc_wr_rq[p]     = wr;
      bus.mc_rq_cyc[p]    = 1'b1;
   endtask

   task automatic release_port(input int p);
      bus.mc_rq_cyc[p] = 1'b0;
      bus.mc_rd_rq[p]  = 1'b0;
      bus.mc_wr_rq[p]  = 1'b0;
   endtask

   task automatic wait_pulse(input int p, input bit rdrs, input string tag, input int exp_cyc);
      int cyc  = 0;
      bit seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         if ((rdrs ? bus.cmc_rd_rs[p] : bus.cmc_addr_ack[p]) === 1'b1) begin
            seen = 1'b1;
            cyc  = i;
         end
      end
      check(tag, cyc, exp_cyc);
   endtask

   task automatic write_restart(input int p, input logic [35:0] data);
      bus.mb_in[p*36 +: 36] = data;
      bus.mc_wr_rs[p]       = 1'b1;
      @(negedge clk);
      bus.mc_wr_rs[p]       = 1'b0;
   endtask

   task automatic write_word(input int p, input logic [17:0] addr, input logic [35:0] data);
      drive_req(p, addr, 1'b0, 1'b1);
      exp_ack_q.push_back(p);
      wait_pulse(p, 1'b0, "wr_ack_lat", ACK_DLY + 1);
      write_restart(p, data);
      release_port(p);
      repeat (WR_DLY + 3) @(negedge clk);
   endtask

   task automatic read_word(input int p, input logic [17:0] addr, input logic [35:0] exp, input int hold);
      drive_req(p, addr, 1'b1, 1'b0);
      exp_ack_q.push_back(p);
      exp_rd_q.push_back('{port: p, data: exp});
      wait_pulse(p, 1'b0, "rd_ack_lat", ACK_DLY + 1);
      wait_pulse(p, 1'b1, "rd_rs_lat", RD_DLY);
      repeat (hold) @(negedge clk);
      release_port(p);
      repeat (WR_DLY + 3) @(negedge clk);
   endtask

   task automatic miss_probe(input string tag, input logic [17:0] addr, input int word);
      int          a1   = n_ack[1];
      logic [35:0] orig = dut.core[word];
      drive_req(1, addr, 1'b0, 1'b1);
      repeat (15) @(negedge clk);
      check({tag, "_no_ack"}, n_ack[1] - a1, 0);
      check({tag, "_core"}, dut.core[word], orig);
      release_port(1);
      @(negedge clk);
   endtask

   initial begin
      int a0, r0, a2;
      bus.memsel     = '1;
      bus.mc_rq_cyc  = '0;
      bus.mc_rd_rq   = '0;
      bus.mc_wr_rq   = '0;
      bus.mc_wr_rs   = '0;
      bus.fmc_select = '0;
      bus.ma         = '0;
      bus.sel        = '0;
      bus.mb_in      = '0;
      repeat (3) @(negedge clk);
      check("rst_ack", bus.cmc_addr_ack, 0);
      check("rst_rd_rs", bus.cmc_rd_rs, 0);
      check("rst_mb_out_lo", bus.mb_out[63:0], 0);
      check("rst_mb_out_hi", bus.mb_out[143:64], 0);
      reset = 1'b0;
      @(negedge clk);

      write_word(0, 18'o4, 36'o222333111666);
      write_word(0, 18'o5, 36'o7);
      write_word(0, 18'o20, 36'o123456654321);
      check("wr_core020", dut.core[16], 36'o123456654321);

      // Read-restore, held in REL long enough to expose a double service.
      a0 = n_ack[0];
      read_word(0, 18'o4, 36'o222333111666, 10);
      check("rd_core4_restored", dut.core[4], 36'o222333111666);
      check("rd_single_ack", n_ack[0] - a0, 1);

      // Read-modify-write.
      a0 = n_ack[0];
      r0 = n_rd[0];
      drive_req(0, 18'o5, 1'b1, 1'b1);
      exp_ack_q.push_back(0);
      exp_rd_q.push_back('{port: 0, data: 36'o7});
      wait_pulse(0, 1'b0, "rmw_ack_lat", ACK_DLY + 1);
      wait_pulse(0, 1'b1, "rmw_rd_lat", RD_DLY);
      write_restart(0, 36'o10);
      release_port(0);
      repeat (WR_DLY + 3) @(negedge clk);
      check("rmw_core5", dut.core[5], 36'o10);
      check("rmw_one_ack", n_ack[0] - a0, 1);
      check("rmw_one_rd_rs", n_rd[0] - r0, 1);

      // Write-only abandoned before wr_rs: word is cleared, then the original comes back.
      drive_req(0, 18'o20, 1'b0, 1'b1);
      exp_ack_q.push_back(0);
      wait_pulse(0, 1'b0, "wabort_ack_lat", ACK_DLY + 1);
      @(negedge clk);
      check("wabort_cleared", dut.core[16], 0);
      release_port(0);
      repeat (WR_DLY + 3) @(negedge clk);
      check("wabort_restored", dut.core[16], 36'o123456654321);

      // Simultaneous requests on ports 0 and 2.
      a2 = n_ack[2];
      drive_req(0, 18'o4, 1'b1, 1'b0);
      drive_req(2, 18'o5, 1'b1, 1'b0);
      exp_ack_q.push_back(0);
      exp_ack_q.push_back(2);
      exp_rd_q.push_back('{port: 0, data: 36'o222333111666});
      exp_rd_q.push_back('{port: 2, data: 36'o10});
      wait_pulse(0, 1'b0, "prio_p0_ack_lat", ACK_DLY + 1);
      wait_pulse(0, 1'b1, "prio_p0_rd_lat", RD_DLY);
      repeat (10) @(negedge clk);
      check("prio_p2_waits", n_ack[2] - a2, 0);
      release_port(0);
      wait_pulse(2, 1'b0, "prio_p2_ack_lat", ACK_DLY + 2);
      wait_pulse(2, 1'b1, "prio_p2_rd_lat", RD_DLY);
      release_port(2);
      repeat (WR_DLY + 3) @(negedge clk);
      check("prio_core5", dut.core[5], 36'o10);

      // Requests that must be ignored.
      miss_probe("miss_range", {4'b0011, 14'o20}, 16);
      bus.fmc_select[1] = 1'b1;
      miss_probe("miss_fmc", 18'o20, 16);
      bus.fmc_select[1] = 1'b0;
      bus.memsel[1] = 1'b0;
      miss_probe("miss_memsel", 18'o20, 16);
      bus.memsel[1] = 1'b1;

      // Reset during WWAIT of an RMW.
      write_word(0, 18'o30, 36'o777);
      drive_req(0, 18'o30, 1'b1, 1'b1);
      exp_ack_q.push_back(0);
      exp_rd_q.push_back('{port: 0, data: 36'o777});
      wait_pulse(0, 1'b0, "rstmid_ack_lat", ACK_DLY + 1);
      wait_pulse(0, 1'b1, "rstmid_rd_lat", RD_DLY);
      #2 reset = 1'b1;
      #1;
      check("rstmid_ack", bus.cmc_addr_ack, 0);
      check("rstmid_rd_rs", bus.cmc_rd_rs, 0);
      check("rstmid_mb_out_lo", bus.mb_out[63:0], 0);
      check("rstmid_mb_out_hi", bus.mb_out[143:64], 0);
      release_port(0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rstmid_word_cleared", dut.core[24], 0);
      read_word(0, 18'o30, 36'd0, 2);
      read_word(0, 18'o4, 36'o222333111666, 2);
      check("post_rst_core4", dut.core[4], 36'o222333111666);

      check("queues_drained", exp_ack_q.size() + exp_rd_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
